// File: rtl/execute_muldiv_pkg.sv
// Shared encodings for the execute stage: forwarding, ALU, branch, load/store and mul/div codes.
package execute_muldiv_pkg;

  localparam logic [1:0] FWD_NORMAL    = 2'd0;
  localparam logic [1:0] FWD_WRITEMEM  = 2'd1;
  localparam logic [1:0] FWD_WRITEBACK = 2'd2;

  localparam logic [2:0] NOTLOAD  = 3'd0;
  localparam logic [1:0] NOTSTORE = 2'd0;

  localparam logic [3:0] BNONE = 4'd0;
  localparam logic [3:0] BJAL  = 4'd1;
  localparam logic [3:0] BJALR = 4'd2;
  localparam logic [3:0] BEQ   = 4'd3;
  localparam logic [3:0] BNE   = 4'd4;
  localparam logic [3:0] BLT   = 4'd5;
  localparam logic [3:0] BGE   = 4'd6;
  localparam logic [3:0] BLTU  = 4'd7;
  localparam logic [3:0] BGEU  = 4'd8;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  // Matches the RV32M funct3 ordering.
  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_BUSY = 2'd1;
  localparam logic [1:0] MD_DONE = 2'd2;

  typedef struct packed {
    logic       write_reg;
    logic [2:0] info_load;
    logic [1:0] info_store;
    logic [4:0] dstreg_addr;
  } e_ctrl_t;

  function automatic logic is_jump(input logic [3:0] branch);
    return (branch == BJAL) || (branch == BJALR);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide engine: pipelined multiplier, restoring divider, fixed-latency FSM.
module muldiv_unit
  import execute_muldiv_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      mdcode,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned MaxLat  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW    = $clog2(MaxLat + 1);
  localparam int unsigned MulPipe = (MUL_CYCLES > 1) ? MUL_CYCLES - 1 : 1;

  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d, lat;
  logic              issue;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q, dvs_q, rem_q, quo_q;
  logic              qneg_q, rneg_q, dbz_q;
  logic              sgn, a_neg, b_neg;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic              mul_a_s, mul_b_s;
  logic [2*XLEN-1:0] prod, mul_out;
  logic [2*XLEN-1:0] mul_pipe [MulPipe];

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                  input logic [XLEN-1:0] quo,
                                                  input logic [XLEN-1:0] dvs);
    logic [XLEN:0] sh;
    logic          q;
    sh = {rem, quo[XLEN-1]};
    q  = (sh >= {1'b0, dvs});
    if (q) sh = sh - {1'b0, dvs};
    return {sh[XLEN-1:0], quo[XLEN-2:0], q};
  endfunction

  always_comb begin
    sgn   = mdcode[2] & ~mdcode[0];
    a_neg = sgn & op_a[XLEN-1];
    b_neg = sgn & op_b[XLEN-1];
    a_abs = a_neg ? -op_a : op_a;
    b_abs = b_neg ? -op_b : op_b;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    lat     = mdcode[2] ? CntW'(DIV_CYCLES) : CntW'(MUL_CYCLES);
    case (state_q)
      MD_IDLE: begin
        if (start && !flush) begin
          issue   = 1'b1;
          cnt_d   = lat - 1'b1;
          state_d = (lat == CntW'(1)) ? MD_DONE : MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (flush) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) state_d = MD_DONE;
        end
      end
      // Always returns to idle so a still-asserted start cannot re-issue the same op.
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  assign busy = issue | (state_q == MD_BUSY);
  assign done = (state_q == MD_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_MUL;
      a_q     <= '0;
      b_q     <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (issue) begin
        op_q           <= mdcode;
        a_q            <= op_a;
        b_q            <= op_b;
        dvs_q          <= b_abs;
        {rem_q, quo_q} <= div_step('0, a_abs, b_abs);
        qneg_q         <= a_neg ^ b_neg;
        rneg_q         <= a_neg;
        dbz_q          <= (op_b == '0);
      end else if (state_q == MD_BUSY) begin
        {rem_q, quo_q} <= div_step(rem_q, quo_q, dvs_q);
      end
    end
  end

  always_comb begin
    mul_a_s = ((op_q == MD_MULH) || (op_q == MD_MULHSU)) && a_q[XLEN-1];
    mul_b_s = (op_q == MD_MULH) && b_q[XLEN-1];
    prod    = {{XLEN{mul_a_s}}, a_q} * {{XLEN{mul_b_s}}, b_q};
  end

  always_ff @(posedge clk) begin
    mul_pipe[0] <= prod;
    for (int unsigned i = 1; i < MulPipe; i++) mul_pipe[i] <= mul_pipe[i-1];
  end

  assign mul_out = (MUL_CYCLES > 1) ? mul_pipe[MulPipe-1] : prod;

  always_comb begin
    result = '0;
    case (op_q)
      MD_MUL:                        result = mul_out[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  result = mul_out[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:               result = dbz_q ? '1 : (qneg_q ? -quo_q : quo_q);
      MD_REM, MD_REMU:               result = dbz_q ? a_q : (rneg_q ? -rem_q : rem_q);
      default:                       result = '0;
    endcase
  end

endmodule

// File: rtl/execute_muldiv.sv
// Execute stage: ALU, branch compare, operand forwarding and the E register, plus mul/div stalls.
module execute_muldiv
  import execute_muldiv_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] r1_data,
  input  logic [XLEN-1:0] r2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic [3:0]      alucode,
  input  logic            md_valid,
  input  logic [2:0]      mdcode,
  input  logic            using_r2,
  input  logic            using_pc,
  input  logic [1:0]      forward_sig1,
  input  logic [1:0]      forward_sig2,
  input  logic [XLEN-1:0] forward_data_writemem,
  input  logic [XLEN-1:0] forward_data_writeback,
  input  logic            write_reg,
  input  logic [2:0]      info_load,
  input  logic [1:0]      info_store,
  input  logic [3:0]      info_branch,
  input  logic [4:0]      dstreg_addr,
  input  logic            flush,
  output logic            stall_out,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] branch_pc,
  output logic [XLEN-1:0] rs2E,
  output logic            branch_signal,
  output logic            write_regE,
  output logic [2:0]      info_loadE,
  output logic [1:0]      info_storeE,
  output logic [4:0]      dstreg_addrE
);

  localparam int unsigned ShW = $clog2(XLEN);

  logic [XLEN-1:0] fwd1, fwd2, op1, op2, alu_out, md_result;
  logic [ShW-1:0]  shamt;
  logic            taken, md_busy, md_done;
  e_ctrl_t         ctrl;

  always_comb begin
    case (forward_sig1)
      FWD_WRITEMEM:  fwd1 = forward_data_writemem;
      FWD_WRITEBACK: fwd1 = forward_data_writeback;
      default:       fwd1 = r1_data;
    endcase
    case (forward_sig2)
      FWD_WRITEMEM:  fwd2 = forward_data_writemem;
      FWD_WRITEBACK: fwd2 = forward_data_writeback;
      default:       fwd2 = r2_data;
    endcase
  end

  assign op1   = using_pc ? pc : fwd1;
  assign op2   = using_r2 ? fwd2 : imm;
  assign shamt = op2[ShW-1:0];

  always_comb begin
    case (alucode)
      ALU_ADD:  alu_out = op1 + op2;
      ALU_SUB:  alu_out = op1 - op2;
      ALU_SLL:  alu_out = op1 << shamt;
      ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, (op1 < op2)};
      ALU_XOR:  alu_out = op1 ^ op2;
      ALU_SRL:  alu_out = op1 >> shamt;
      ALU_SRA:  alu_out = $signed(op1) >>> shamt;
      ALU_OR:   alu_out = op1 | op2;
      ALU_AND:  alu_out = op1 & op2;
      ALU_LUI:  alu_out = op2;
      default:  alu_out = op1 + op2;
    endcase
  end

  always_comb begin
    case (info_branch)
      BJAL, BJALR: taken = 1'b1;
      BEQ:         taken = (fwd1 == fwd2);
      BNE:         taken = (fwd1 != fwd2);
      BLT:         taken = ($signed(fwd1) < $signed(fwd2));
      BGE:         taken = ($signed(fwd1) >= $signed(fwd2));
      BLTU:        taken = (fwd1 < fwd2);
      BGEU:        taken = (fwd1 >= fwd2);
      default:     taken = 1'b0;
    endcase
  end

  assign ctrl = '{write_reg: write_reg, info_load: info_load, info_store: info_store,
                  dstreg_addr: dstreg_addr};

  muldiv_unit #(
    .XLEN      (XLEN),
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (md_valid),
    .flush (flush),
    .mdcode(mdcode),
    .op_a  (fwd1),
    .op_b  (fwd2),
    .busy  (md_busy),
    .done  (md_done),
    .result(md_result)
  );

  assign stall_out = md_busy;

  // Bubbles keep alu_result and rs2E so downstream bypass values stay stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result    <= '0;
      branch_pc     <= '0;
      rs2E          <= '0;
      branch_signal <= 1'b0;
      write_regE    <= 1'b0;
      info_loadE    <= NOTLOAD;
      info_storeE   <= NOTSTORE;
      dstreg_addrE  <= '0;
    end else if (flush) begin
      branch_pc     <= '0;
      branch_signal <= 1'b0;
      write_regE    <= 1'b0;
      info_loadE    <= NOTLOAD;
      info_storeE   <= NOTSTORE;
      dstreg_addrE  <= '0;
    end else if (md_done) begin
      alu_result    <= md_result;
      branch_pc     <= alu_out;
      rs2E          <= fwd2;
      branch_signal <= 1'b0;
      write_regE    <= ctrl.write_reg;
      info_loadE    <= ctrl.info_load;
      info_storeE   <= ctrl.info_store;
      dstreg_addrE  <= ctrl.dstreg_addr;
    end else if (md_busy) begin
      branch_signal <= 1'b0;
      write_regE    <= 1'b0;
      info_loadE    <= NOTLOAD;
      info_storeE   <= NOTSTORE;
      dstreg_addrE  <= '0;
    end else begin
      alu_result    <= is_jump(info_branch) ? pc + XLEN'(4) : alu_out;
      branch_pc     <= alu_out;
      rs2E          <= fwd2;
      branch_signal <= taken;
      write_regE    <= ctrl.write_reg;
      info_loadE    <= ctrl.info_load;
      info_storeE   <= ctrl.info_store;
      dstreg_addrE  <= ctrl.dstreg_addr;
    end
  end

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv: forwarding/ALU, mul/div latency and results, flush and reset.
module tb_execute_muldiv;
  import execute_muldiv_pkg::*;

  logic        clk, rst;
  logic [31:0] r1_data, r2_data, imm, pc;
  logic [3:0]  alucode;
  logic        md_valid;
  logic [2:0]  mdcode;
  logic        using_r2, using_pc;
  logic [1:0]  forward_sig1, forward_sig2;
  logic [31:0] forward_data_writemem, forward_data_writeback;
  logic        write_reg;
  logic [2:0]  info_load;
  logic [1:0]  info_store;
  logic [3:0]  info_branch;
  logic [4:0]  dstreg_addr;
  logic        flush;
  logic        stall_out;
  logic [31:0] alu_result, branch_pc, rs2E;
  logic        branch_signal, write_regE;
  logic [2:0]  info_loadE;
  logic [1:0]  info_storeE;
  logic [4:0]  dstreg_addrE;

  int errors = 0;
  int checks = 0;

  execute_muldiv dut (
    .clk                   (clk),
    .rst                   (rst),
    .r1_data               (r1_data),
    .r2_data               (r2_data),
    .imm                   (imm),
    .pc                    (pc),
    .alucode               (alucode),
    .md_valid              (md_valid),
    .mdcode                (mdcode),
    .using_r2              (using_r2),
    .using_pc              (using_pc),
    .forward_sig1          (forward_sig1),
    .forward_sig2          (forward_sig2),
    .forward_data_writemem (forward_data_writemem),
    .forward_data_writeback(forward_data_writeback),
    .write_reg             (write_reg),
    .info_load             (info_load),
    .info_store            (info_store),
    .info_branch           (info_branch),
    .dstreg_addr           (dstreg_addr),
    .flush                 (flush),
    .stall_out             (stall_out),
    .alu_result            (alu_result),
    .branch_pc             (branch_pc),
    .rs2E                  (rs2E),
    .branch_signal         (branch_signal),
    .write_regE            (write_regE),
    .info_loadE            (info_loadE),
    .info_storeE           (info_storeE),
    .dstreg_addrE          (dstreg_addrE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (md_valid)
      assert (info_branch == BNONE && info_load == NOTLOAD && info_store == NOTSTORE)
        else $error("decoder contract violated: md_valid with load/store/branch info");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop;
    r1_data = '0; r2_data = '0; imm = '0; pc = '0;
    alucode = ALU_ADD; md_valid = 1'b0; mdcode = MD_MUL;
    using_r2 = 1'b0; using_pc = 1'b0;
    forward_sig1 = FWD_NORMAL; forward_sig2 = FWD_NORMAL;
    forward_data_writemem = '0; forward_data_writeback = '0;
    write_reg = 1'b0; info_load = NOTLOAD; info_store = NOTSTORE; info_branch = BNONE;
    dstreg_addr = '0; flush = 1'b0;
  endtask

  task automatic test_reset;
    set_nop;
    rst = 1'b1;
    tick;
    tick;
    checks++;
    if (stall_out !== 1'b0) begin
      $display("FAIL reset stall_out: got %b want 0", stall_out); errors++;
    end
    checks++;
    if ({alu_result, branch_pc, rs2E} !== 96'd0) begin
      $display("FAIL reset data regs: got %h %h %h want 0", alu_result, branch_pc, rs2E); errors++;
    end
    checks++;
    if ({branch_signal, write_regE, info_loadE, info_storeE, dstreg_addrE} !== 12'd0) begin
      $display("FAIL reset ctrl regs: got %b %b %h %h %h want 0", branch_signal, write_regE,
               info_loadE, info_storeE, dstreg_addrE); errors++;
    end
    rst = 1'b0;
  endtask

  task automatic test_alu_forward;
    set_nop;
    forward_sig1 = FWD_WRITEMEM; forward_data_writemem = 32'd5; r1_data = 32'd99; imm = 32'd7;
    write_reg = 1'b1; dstreg_addr = 5'd3;
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      $display("FAIL add stall_out: got %b want 0", stall_out); errors++;
    end
    tick;
    checks++;
    if (alu_result !== 32'd12) begin
      $display("FAIL add fwd-mem result: got %h want 0000000c", alu_result); errors++;
    end
    checks++;
    if (write_regE !== 1'b1 || dstreg_addrE !== 5'd3) begin
      $display("FAIL add ctrl: got wr=%b dst=%0d want wr=1 dst=3", write_regE, dstreg_addrE);
      errors++;
    end
    // SUB with operand 2 from writeback.
    set_nop;
    alucode = ALU_SUB; r1_data = 32'd10; r2_data = 32'd50; using_r2 = 1'b1;
    forward_sig2 = FWD_WRITEBACK; forward_data_writeback = 32'd2;
    tick;
    checks++;
    if (alu_result !== 32'd8 || rs2E !== 32'd2) begin
      $display("FAIL sub fwd-wb: got res=%h rs2=%h want 00000008 00000002", alu_result, rs2E);
      errors++;
    end
    // Undefined forward code falls back to the register value.
    set_nop;
    forward_sig1 = 2'd3; r1_data = 32'd20; forward_data_writemem = 32'd1000; imm = 32'd1;
    tick;
    checks++;
    if (alu_result !== 32'd21) begin
      $display("FAIL fwd undefined code: got %h want 00000015", alu_result); errors++;
    end
    set_nop;
    info_branch = BNE; r1_data = 32'd1; r2_data = 32'd2; using_pc = 1'b1;
    pc = 32'h200; imm = 32'd8;
    tick;
    checks++;
    if (branch_signal !== 1'b1 || branch_pc !== 32'h208) begin
      $display("FAIL bne taken: got sig=%b pc=%h want 1 00000208", branch_signal, branch_pc);
      errors++;
    end
    set_nop;
  endtask

  task automatic test_md_op(input string name, input logic [2:0] code, input logic [31:0] a,
                            input logic [31:0] b, input int lat, input logic [31:0] exp,
                            input bit perturb);
    int stalls;
    int bub;
    set_nop;
    md_valid = 1'b1; mdcode = code; r1_data = a; r2_data = b; using_r2 = 1'b1;
    write_reg = 1'b1; dstreg_addr = 5'd9;
    stalls = 0;
    bub = 0;
    #1;
    while (stall_out === 1'b1 && stalls < 100) begin
      stalls++;
      tick;
      if (write_regE !== 1'b0 || dstreg_addrE !== 5'd0 || info_loadE !== NOTLOAD) bub++;
      if (perturb) begin
        r1_data = r1_data + 32'h111;
        r2_data = ~r2_data;
        forward_data_writemem = $urandom;
      end
      #1;
    end
    checks++;
    if (stalls !== lat) begin
      $display("FAIL %s stall cycles: got %0d want %0d", name, stalls, lat); errors++;
    end
    checks++;
    if (bub !== 0) begin
      $display("FAIL %s bubble: got %0d non-bubble cycles want 0", name, bub); errors++;
    end
    tick;
    checks++;
    if (alu_result !== exp) begin
      $display("FAIL %s result: got %h want %h", name, alu_result, exp); errors++;
    end
    checks++;
    if (write_regE !== 1'b1 || dstreg_addrE !== 5'd9) begin
      $display("FAIL %s commit ctrl: got wr=%b dst=%0d want wr=1 dst=9", name, write_regE,
               dstreg_addrE); errors++;
    end
    set_nop;
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      $display("FAIL %s restart after done: got stall %b want 0", name, stall_out); errors++;
    end
  endtask

  task automatic test_mul;
    test_md_op("mul", MD_MUL, 32'd7, 32'hFFFF_FFFD, 2, 32'hFFFF_FFEB, 1'b0);
    test_md_op("mulhu", MD_MULHU, 32'd7, 32'hFFFF_FFFD, 2, 32'h0000_0006, 1'b0);
    test_md_op("mulh", MD_MULH, 32'hFFFF_FFFD, 32'd7, 2, 32'hFFFF_FFFF, 1'b0);
    test_md_op("mulhsu", MD_MULHSU, 32'hFFFF_FFFD, 32'd7, 2, 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic test_div;
    test_md_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFD, 1'b1);
    test_md_op("rem", MD_REM, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFF, 1'b1);
    test_md_op("divu", MD_DIVU, 32'hFFFF_FFF9, 32'd2, 32, 32'h7FFF_FFFC, 1'b0);
    test_md_op("remu", MD_REMU, 32'hFFFF_FFF9, 32'd2, 32, 32'h0000_0001, 1'b0);
  endtask

  task automatic test_div_corner;
    test_md_op("divu by zero", MD_DIVU, 32'h1234, 32'd0, 32, 32'hFFFF_FFFF, 1'b0);
    test_md_op("rem by zero", MD_REM, 32'h1234, 32'd0, 32, 32'h0000_1234, 1'b0);
    test_md_op("div neg by zero", MD_DIV, 32'hFFFF_FFF9, 32'd0, 32, 32'hFFFF_FFFF, 1'b0);
    test_md_op("rem neg by zero", MD_REM, 32'hFFFF_FFF9, 32'd0, 32, 32'hFFFF_FFF9, 1'b0);
    test_md_op("div overflow", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32, 32'h8000_0000, 1'b0);
    test_md_op("rem overflow", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32, 32'h0000_0000, 1'b0);
  endtask

  task automatic test_flush;
    set_nop;
    md_valid = 1'b1; mdcode = MD_DIV; r1_data = 32'd100; r2_data = 32'd7; using_r2 = 1'b1;
    write_reg = 1'b1; dstreg_addr = 5'd9;
    for (int i = 0; i < 9; i++) tick;
    flush = 1'b1;
    tick;
    set_nop;
    r1_data = 32'd3; imm = 32'd4; write_reg = 1'b1; dstreg_addr = 5'd7;
    checks++;
    if (write_regE !== 1'b0 || branch_pc !== 32'd0) begin
      $display("FAIL flush busy bubble: got wr=%b bpc=%h want 0 0", write_regE, branch_pc);
      errors++;
    end
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      $display("FAIL flush busy stall_out: got %b want 0", stall_out); errors++;
    end
    tick;
    checks++;
    if (alu_result !== 32'd7 || write_regE !== 1'b1 || dstreg_addrE !== 5'd7) begin
      $display("FAIL add after flush: got res=%h wr=%b dst=%0d want 00000007 1 7", alu_result,
               write_regE, dstreg_addrE); errors++;
    end
    // Flush in the issue cycle must prevent the start.
    set_nop;
    md_valid = 1'b1; mdcode = MD_MUL; r1_data = 32'd2; r2_data = 32'd3; using_r2 = 1'b1;
    flush = 1'b1;
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      $display("FAIL flush issue stall_out: got %b want 0", stall_out); errors++;
    end
    tick;
    set_nop;
    #1;
    checks++;
    if (stall_out !== 1'b0 || write_regE !== 1'b0) begin
      $display("FAIL flush issue no start: got stall=%b wr=%b want 0 0", stall_out, write_regE);
      errors++;
    end
  endtask

  task automatic test_reset_mid;
    set_nop;
    r1_data = 32'h55; r2_data = 32'h66;
    tick;
    set_nop;
    md_valid = 1'b1; mdcode = MD_MUL; r1_data = 32'd5; r2_data = 32'd6; using_r2 = 1'b1;
    write_reg = 1'b1; dstreg_addr = 5'd4;
    tick;
    checks++;
    if (alu_result !== 32'h55 || rs2E !== 32'h66) begin
      $display("FAIL md bubble hold: got res=%h rs2=%h want 00000055 00000066", alu_result,
               rs2E); errors++;
    end
    set_nop;
    rst = 1'b1;
    tick;
    checks++;
    if ({alu_result, branch_pc, rs2E} !== 96'd0 || stall_out !== 1'b0) begin
      $display("FAIL reset mid-op: got %h %h %h stall=%b want 0", alu_result, branch_pc, rs2E,
               stall_out); errors++;
    end
    checks++;
    if ({branch_signal, write_regE, info_loadE, info_storeE, dstreg_addrE} !== 12'd0) begin
      $display("FAIL reset mid-op ctrl: got %b %b %h %h %h want 0", branch_signal, write_regE,
               info_loadE, info_storeE, dstreg_addrE); errors++;
    end
    rst = 1'b0;
    info_branch = BJAL; pc = 32'h100; imm = 32'h40; using_pc = 1'b1;
    write_reg = 1'b1; dstreg_addr = 5'd1;
    tick;
    checks++;
    if (alu_result !== 32'h104 || branch_pc !== 32'h140 || branch_signal !== 1'b1) begin
      $display("FAIL jal after reset: got res=%h bpc=%h sig=%b want 00000104 00000140 1",
               alu_result, branch_pc, branch_signal); errors++;
    end
    set_nop;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    set_nop;
    test_reset;
    test_alu_forward;
    test_mul;
    test_div;
    test_div_corner;
    test_flush;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
